// File: rtl/inst_fetch_pkg.sv
// rtl/inst_fetch_pkg.sv - shared types and constants for the instruction fetch unit
// HALT state only exists when INST_FETCH_HALT_EN is defined.
package inst_fetch_pkg;
  localparam int BYTE_W = 8;
  localparam int INST_BYTES = 4;
  localparam logic [BYTE_W-1:0] HALT_OPCODE = 8'hFF;

  typedef enum logic [2:0] {
    F0,
    F1,
    F2,
    F3,
    F4,
    PRESENT
`ifdef INST_FETCH_HALT_EN
    ,
    HALT
`endif
  } fetch_state_t;
endpackage

// File: rtl/inst_fetch_pc.sv
// rtl/inst_fetch_pc.sv - program counter register and byte-address offset adder
module inst_fetch_pc
  import inst_fetch_pkg::*;
#(
  parameter logic [BYTE_W-1:0] RESET_PC = 8'h00
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              advance,
  input  logic [BYTE_W-1:0] target,
  input  logic [1:0]        offset,
  output logic [BYTE_W-1:0] pc,
  output logic [BYTE_W-1:0] addr
);

  // A redirect wins over an accept that lands on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (load) begin
      pc <= target;
    end else if (advance) begin
      pc <= pc + BYTE_W'(INST_BYTES);
    end
  end

  assign addr = pc + {{(BYTE_W-2){1'b0}}, offset};

endmodule

// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - byte-serial instruction fetch into op/a/b/c with stall and redirect
// Optional halt-opcode support is enabled by defining INST_FETCH_HALT_EN.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [BYTE_W-1:0] RESET_PC = 8'h00
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              redirect,
  input  logic [BYTE_W-1:0] target,
  output logic              mem_en,
  output logic [BYTE_W-1:0] mem_addr,
  input  logic [BYTE_W-1:0] mem_data,
  output logic [BYTE_W-1:0] op,
  output logic [BYTE_W-1:0] a,
  output logic [BYTE_W-1:0] b,
  output logic [BYTE_W-1:0] c,
  output logic              valid,
  output logic [BYTE_W-1:0] pc,
  output logic              halted
);

  fetch_state_t state;
  logic         accept;
  logic [1:0]   offset;

  assign accept = (state == PRESENT) && !stall;

  always_comb begin
    offset = 2'd0;
    case (state)
      F1:      offset = 2'd1;
      F2:      offset = 2'd2;
      F3:      offset = 2'd3;
      default: offset = 2'd0;
    endcase
  end

  // Gated by rst so the strobe reads as idle while reset is held.
  assign mem_en = !rst && (state inside {F0, F1, F2, F3});

  inst_fetch_pc #(.RESET_PC(RESET_PC)) u_pc (
    .clk     (clk),
    .rst     (rst),
    .load    (redirect),
    .advance (accept),
    .target  (target),
    .offset  (offset),
    .pc      (pc),
    .addr    (mem_addr)
  );

`ifdef INST_FETCH_HALT_EN
  logic halted_q;
  assign halted = halted_q;
`else
  assign halted = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= F0;
      op    <= '0;
      a     <= '0;
      b     <= '0;
      c     <= '0;
      valid <= 1'b0;
`ifdef INST_FETCH_HALT_EN
      halted_q <= 1'b0;
`endif
    end else if (redirect) begin
      // Read data arriving in F0 is never captured, so an abandoned byte dies here.
      state <= F0;
      valid <= 1'b0;
`ifdef INST_FETCH_HALT_EN
      halted_q <= 1'b0;
`endif
    end else begin
      case (state)
        F0: state <= F1;
        F1: begin
          op    <= mem_data;
          state <= F2;
        end
        F2: begin
          a     <= mem_data;
          state <= F3;
        end
        F3: begin
          b     <= mem_data;
          state <= F4;
        end
        F4: begin
          c     <= mem_data;
          valid <= 1'b1;
          state <= PRESENT;
        end
        PRESENT: begin
          if (!stall) begin
            valid <= 1'b0;
`ifdef INST_FETCH_HALT_EN
            if (op == HALT_OPCODE) begin
              state    <= HALT;
              halted_q <= 1'b1;
            end else begin
              state <= F0;
            end
`else
            state <= F0;
`endif
          end
        end
`ifdef INST_FETCH_HALT_EN
        HALT: state <= HALT;
`endif
        default: state <= F0;
      endcase
    end
  end

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction fetch unit feeding the pipeline's instruction register. Reads each 4-byte instruction (opcode, A, B, C) from a byte-wide synchronous instruction memory and assembles it. Presents the instruction with `valid` and holds it while the downstream `stall` is high. Supports a PC redirect from the branch logic.

## Interface
- `RESET_PC`, 8'h00: PC loaded on reset.
- `clk`  in  1  single clock; all state updates on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `stall`  in  1  downstream hold; instruction accepted on a posedge where `valid & ~stall`.
- `redirect`  in  1  load `target` into PC and abandon the current fetch.
- `target`  in  8  redirect PC.
- `mem_en`  out  1  memory read strobe.
- `mem_addr`  out  8  byte address.
- `mem_data`  in  8  read data; valid the cycle after `mem_en`.
- `op`, `a`, `b`, `c`  out  8 each  assembled instruction fields.
- `valid`  out  1  fields hold a complete, unaccepted instruction.
- `pc`  out  8  address of the opcode byte of the current instruction.
- `halted`  out  1  fetch stopped on the halt opcode (see Configuration).

## Operation
- Reset values:
  - State F0, `pc` = RESET_PC.
  - `op`, `a`, `b`, `c`, `valid`, `halted`, `mem_en` all 0.
  - `mem_addr` = RESET_PC.
- FSM states F0, F1, F2, F3, F4, PRESENT (and HALT under macro):
  - F0: `mem_en`=1, `mem_addr`=pc; go to F1.
  - F1: capture `mem_data` into `op`; `mem_en`=1, `mem_addr`=pc+1; go to F2.
  - F2: capture into `a`; issue pc+2; go to F3.
  - F3: capture into `b`; issue pc+3; go to F4.
  - F4: capture into `c`; `mem_en`=0; go to PRESENT.
  - PRESENT: `valid`=1, `mem_en`=0, fields stable.
    - `stall`=1: stay.
    - `stall`=0: accept; pc <= pc+4; go to F0 (or HALT, see Configuration).
- Address arithmetic is 8-bit modulo 256. Byte addresses and pc+4 wrap silently (e.g. pc=8'hFE fetches FE, FF, 00, 01; next pc=8'h02).
- `redirect` has priority over everything except `rst`, in any state:
  - pc <= `target`, state <= F0, `valid` <= 0, `halted` <= 0.
  - Any data returning from an abandoned read is discarded.
- `redirect` together with accept in PRESENT: the instruction counts as consumed, and pc takes `target`, not pc+4.
- `rst` in any state (mid-fetch, PRESENT, HALT) returns to reset values on the next edge. Any outstanding read is ignored.
- Fields `op`/`a`/`b`/`c` change only on capture in F1–F4. They retain stale values while `valid`=0.

## Timing
- Fetch latency: 5 cycles from entering F0 to `valid`=1. First `valid` is the 6th cycle after `rst` deasserts (F0 is cycle 1).
- Throughput with `stall`=0 throughout: one instruction per 6 cycles, `valid` high 1 of 6.
- `valid`, fields, `pc`, and `halted` are registered. `mem_en`/`mem_addr` are decoded from state and pc.
- Redirect effect: `valid` low the cycle after the `redirect` edge. A read of `target` issues that same cycle.

## Configuration
- `INST_FETCH_HALT_EN` defined:
  - Opcode 8'hFF is halt.
  - On acceptance of an instruction with `op`=8'hFF, enter HALT instead of F0.
  - HALT: `mem_en`=0, `valid`=0, `halted`=1, pc already advanced by 4.
  - Leave HALT only via `redirect` (to F0) or `rst`.
- Not defined: 8'hFF is an ordinary opcode, HALT state absent, `halted` tied 0.

## Structure
- Shared package `inst_fetch_pkg`:
  - State enum.
  - `INST_BYTES` = 4.
  - `HALT_OPCODE` = 8'hFF.
  - Field width constant `BYTE_W` = 8.
- One sub-module: `inst_fetch_pc`. Holds the PC register and handles reset load, redirect load, +4 advance, and the +0..+3 byte-address offset mux.

## Test plan
- Memory bytes 00..03 = 10, 20, 30, 40; `stall`=0; release `rst` → `mem_addr` 00, 01, 02, 03 on cycles 1–4; `valid`=1 on cycle 6 with op=10, a=20, b=30, c=40; next `mem_addr`=04 on cycle 7.
- Hold `stall`=1 for 10 cycles while `valid` → fields and `pc`=00 stable, `mem_en`=0. Drop `stall` → one acceptance, pc=04.
- Pulse `redirect` with `target`=8'h80 during F2 → `valid` stays 0; next read at 80; bytes at 80..83 are presented, not the old instruction.
- RESET_PC=8'hFE, bytes FE, FF, 00, 01 = 1, 2, 3, 4 → op=1, a=2, b=3, c=4; after accept pc=8'h02.
- `INST_FETCH_HALT_EN` defined, op=FF at 04 → after accept `halted`=1, `mem_en`=0 for 20 cycles. `redirect` to 00 → `halted`=0, fetch resumes. Without the macro, FF is presented and fetch continues at 08.
- Assert `rst` in PRESENT and in F3 → next cycle all outputs at reset values, `mem_addr`=RESET_PC.
